shift_add_mult: RTL and testbench
=================================

# shift_add_mult

Sequential 16x16 unsigned shift-and-add multiplier for the ALU. It is the first clocked consumer of the 16-bit adder datapath: it reuses one 16-bit add per cycle over 16 iterations instead of building an array multiplier. A start/busy/done handshake connects it to the ALU control. The 32-bit registered product feeds the ALU result mux.

## Interface
- WIDTH, 16, operand width; product is 2*WIDTH; only 16 is verified.
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request; accepted only when busy=0.
- a  input  WIDTH  multiplicand; sampled on the accepting edge only.
- b  input  WIDTH  multiplier; sampled on the accepting edge only.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; product is valid and updated.
- product  output  2*WIDTH  registered unsigned a*b; holds until the next done.

## Operation
- Two FSM states, IDLE and RUN. A separate registered done flag.
- IDLE with start=1:
  - load mcand<=a and acc<={WIDTH'b0, b};
  - set count<=0 and go to RUN;
  - set busy<=1.
- IDLE with start=0: hold all state.
- Each RUN cycle, acc is a 2*WIDTH accumulator:
  - if acc[0]=1, compute {c,s} = acc[2W-1:W] + mcand with cin=0, then acc <= {c, s, acc[W-1:1]};
  - if acc[0]=0, acc <= {1'b0, acc[2W-1:1]};
  - count <= count+1.
- Width rule: the adder carry-out is the MSB shifted in. It is never dropped, so there is no overflow.
- On the RUN cycle where count=WIDTH-1:
  - product <= the next acc value;
  - done <= 1 and busy <= 0;
  - state goes to IDLE.
- done clears on the next edge unconditionally.
- start while busy=1 is ignored and has no side effects. a and b are don't-care outside the accepting edge.
- start in the cycle where done=1 is accepted, since state is already IDLE. This allows back-to-back operation.
- Reset values: state IDLE, busy 0, done 0, product 0, acc 0, mcand 0, count 0.
- Reset mid-operation aborts the operation. No done pulse is issued, product reads 0, and there is no resume.

## Timing
- Accepting edge is T0.
- busy=1 in the cycles after T0 through T15.
- RUN edges are T1..T16.
- done=1 and the new product are visible in the cycle after T16. Latency is 16 cycles from the accepting edge.
- busy and done are never high in the same cycle.
- Maximum throughput is one operation per 17 cycles, with start asserted in each done cycle.
- Outputs are registered only; there is no combinational path from start, a or b to any output.
- The critical path is one 16-bit add plus the acc mux.

## Structure
- Package mult_pkg holds:
  - MULT_WIDTH localparam (16);
  - the state enum {IDLE, RUN};
  - CNT_W = $clog2(MULT_WIDTH).
- One sub-module, add16_cout: combinational WIDTH-bit adder with ports A, B, cin, sum, carry_out.
  - Instantiated once.
  - Generate-loop ripple form with correct carry: c[i+1] = G[i] | (P[i] & c[i]), where P = A^B and G = A&B.
- Top level holds the FSM, counter, mcand/acc/product registers and the done flag.

## Test plan
- Basic multiply: reset, then start with a=0x0003, b=0x0005.
  - busy rises after T0.
  - done pulses exactly 16 cycles later with product=0x0000000F.
  - busy=0 while done=1.
- Full-range carry path: a=0xFFFF, b=0xFFFF gives product=0xFFFE0001. Also a=0x8000, b=0x0002 gives 0x00010000.
- Zero and identity: a=0x0000, b=0x1234 gives 0x00000000. Then a=0xABCD, b=0x0001 gives 0x0000ABCD.
- Busy protection: start a=2, b=3. Pulse start with a=7, b=7 at T5 and T10. Only one done at T16+1, with product=0x00000006.
- Back-to-back: assert start in the done cycle with new operands a=0x0100, b=0x0100.
  - Second done occurs 17 cycles after the first, with product=0x00010000.
  - The prior product holds between the two done pulses.
- Reset mid-operation: start a=0x00FF, b=0x00FF, then drop rst_n at T8 asynchronously, not aligned to clk.
  - busy, done and product go to 0 immediately.
  - No done pulse follows.
  - A new start after release gives 0x0000FE01.

Source files
------------

// File: rtl/shift_add_mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the sequential shift-and-add multiplier.
//   MULT_WIDTH : default operand width (product is 2*MULT_WIDTH)
//   CNT_W      : width of the iteration counter for MULT_WIDTH
//   state_t    : multiplier FSM states
// ---------------------------------------------------------------------------
package mult_pkg;

   localparam int MULT_WIDTH = 16;
   localparam int CNT_W      = $clog2(MULT_WIDTH);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage : mult_pkg

// File: rtl/shift_add_mult_add16_cout.sv
// ---------------------------------------------------------------------------
// add16_cout
// Combinational WIDTH-bit ripple-carry adder with carry-out.
// Ports:
//   A, B      : input  [WIDTH-1:0] addends
//   cin       : input             carry-in
//   sum       : output [WIDTH-1:0] A + B + cin (low WIDTH bits)
//   carry_out : output            carry out of the MSB
// ---------------------------------------------------------------------------
module add16_cout #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out
);

   logic [WIDTH-1:0] p;
   logic [WIDTH-1:0] g;
   logic [WIDTH:0]   c;

   assign c[0] = cin;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         assign p[gi]    = A[gi] ^ B[gi];
         assign g[gi]    = A[gi] & B[gi];
         assign sum[gi]  = p[gi] ^ c[gi];
         assign c[gi+1]  = g[gi] | (p[gi] & c[gi]);
      end
   endgenerate

   assign carry_out = c[WIDTH];

endmodule : add16_cout

// File: rtl/shift_add_mult.sv
// ---------------------------------------------------------------------------
// shift_add_mult
// Sequential unsigned WIDTH x WIDTH multiplier: one WIDTH-bit add and a
// one-bit right shift of a 2*WIDTH accumulator per cycle, WIDTH cycles.
// Ports:
//   clk     : input              rising-edge clock
//   rst_n   : input              asynchronous active-low reset
//   start   : input              request, accepted only while busy=0
//   a       : input  [WIDTH-1:0] multiplicand, sampled on the accepting edge
//   b       : input  [WIDTH-1:0] multiplier, sampled on the accepting edge
//   busy    : output             operation in progress
//   done    : output             one-cycle pulse, product just updated
//   product : output [2W-1:0]    registered a*b, held until the next done
// ---------------------------------------------------------------------------
module shift_add_mult
   import mult_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_t             state_q;
   logic [WIDTH-1:0]   mcand_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] acc_d;
   logic [CW-1:0]      count_q;
   logic               busy_q;
   logic               done_q;
   logic [2*WIDTH-1:0] product_q;

   logic [WIDTH-1:0]   add_sum;
   logic               add_cout;

   // Upper half of the accumulator plus the multiplicand; the carry-out
   // becomes the new MSB so no product bit is ever lost.
   add16_cout #(
      .WIDTH (WIDTH)
   ) u_add (
      .A         (acc_q[2*WIDTH-1:WIDTH]),
      .B         (mcand_q),
      .cin       (1'b0),
      .sum       (add_sum),
      .carry_out (add_cout)
   );

   // Low half of acc initially holds the multiplier; its LSB selects
   // add-then-shift versus plain shift, and product bits fill in from the top.
   always_comb begin
      acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
      if (acc_q[0]) begin
         acc_d = {add_cout, add_sum, acc_q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         mcand_q   <= '0;
         acc_q     <= '0;
         count_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         product_q <= '0;
      end else begin
         // done is a single-cycle pulse regardless of state.
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  mcand_q <= a;
                  acc_q   <= {{WIDTH{1'b0}}, b};
                  count_q <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end
            end
            RUN: begin
               acc_q   <= acc_d;
               count_q <= count_q + 1'b1;
               if (count_q == CNT_LAST) begin
                  product_q <= acc_d;
                  done_q    <= 1'b1;
                  busy_q    <= 1'b0;
                  state_q   <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign product = product_q;

endmodule : shift_add_mult

// File: tb/tb_shift_add_mult.sv
// ---------------------------------------------------------------------------
// tb_shift_add_mult
// Directed self-checking bench for shift_add_mult. Each task drives one
// scenario and compares against hand-computed products and latencies.
// ---------------------------------------------------------------------------
module tb_shift_add_mult;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        busy;
   logic        done;
   logic [31:0] product;

   int checks = 0;
   int errors = 0;

   shift_add_mult #(.WIDTH(16)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present operands so the next rising edge is the accepting edge T0;
   // returns 1ns after T0 with start already dropped.
   task automatic do_start(input logic [15:0] av, input logic [15:0] bv);
      start = 1'b1;
      a     = av;
      b     = bv;
      @(posedge clk);
      #1;
      start = 1'b0;
      a     = 16'hxxxx;
      b     = 16'hxxxx;
   endtask

   // Counts edges from T0 until done is seen (bounded by limit).
   task automatic wait_done(input int limit, output int cycles, output bit overlap);
      cycles  = 0;
      overlap = 1'b0;
      do begin
         @(posedge clk);
         #1;
         cycles++;
         if (busy && done) overlap = 1'b1;
      end while (!done && cycles < limit);
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
      checks++;
      if (product !== 32'h0) begin errors++; $display("FAIL reset_product: got %h want 00000000", product); end
      @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL idle_hold: busy=%b done=%b want 0/0", busy, done);
      end
      $display("reset: busy=%b done=%b product=%h", busy, done, product);
   endtask

   task automatic test_basic();
      int  cyc;
      bit  ovl;
      do_start(16'h0003, 16'h0005);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_rise: got %b want 1", busy); end
      wait_done(40, cyc, ovl);
      checks++;
      if (cyc !== 16 || done !== 1'b1) begin
         errors++; $display("FAIL basic_latency: got %0d cycles done=%b want 16/1", cyc, done);
      end
      checks++;
      if (product !== 32'h0000000F) begin errors++; $display("FAIL basic_product: got %h want 0000000f", product); end
      checks++;
      if (busy !== 1'b0 || ovl) begin errors++; $display("FAIL basic_busy_done_excl: busy=%b overlap=%b want 0/0", busy, ovl); end
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b want 0", done); end
      $display("op 0003*0005 -> %h in %0d cycles", product, cyc);
   endtask

   task automatic test_products();
      logic [15:0] av [4] = '{16'hFFFF, 16'h8000, 16'h0000, 16'hABCD};
      logic [15:0] bv [4] = '{16'hFFFF, 16'h0002, 16'h1234, 16'h0001};
      logic [31:0] ev [4] = '{32'hFFFE0001, 32'h00010000, 32'h00000000, 32'h0000ABCD};
      int  cyc;
      bit  ovl;
      for (int i = 0; i < 4; i++) begin
         do_start(av[i], bv[i]);
         wait_done(40, cyc, ovl);
         checks++;
         if (cyc !== 16 || done !== 1'b1) begin
            errors++; $display("FAIL prod%0d_latency: got %0d cycles done=%b want 16/1", i, cyc, done);
         end
         checks++;
         if (product !== ev[i]) begin
            errors++; $display("FAIL prod%0d_value: got %h want %h", i, product, ev[i]);
         end
         $display("op %h*%h -> %h in %0d cycles", av[i], bv[i], product, cyc);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_busy_protect();
      int          n_done = 0;
      int          first_k = -1;
      logic [31:0] first_p = '0;
      bit          busy_drop = 1'b0;
      do_start(16'h0002, 16'h0003);
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (k < 16 && busy !== 1'b1) busy_drop = 1'b1;
         if (done) begin
            n_done++;
            if (first_k < 0) begin first_k = k; first_p = product; end
         end
         // Start pulses land on edges T5 and T10.
         start = (k == 4 || k == 9);
         a     = 16'h0007;
         b     = 16'h0007;
      end
      start = 1'b0;
      checks++;
      if (n_done !== 1 || first_k !== 16) begin
         errors++; $display("FAIL busy_protect_done: got %0d pulses first at %0d want 1 at 16", n_done, first_k);
      end
      checks++;
      if (first_p !== 32'h00000006) begin errors++; $display("FAIL busy_protect_product: got %h want 00000006", first_p); end
      checks++;
      if (busy_drop) begin errors++; $display("FAIL busy_protect_busy: got busy low mid-op want high"); end
      $display("op 0002*0003 with ignored starts -> %h, %0d done pulses", first_p, n_done);
   endtask

   task automatic test_back_to_back();
      int  cyc;
      bit  ovl;
      bit  hold_bad = 1'b0;
      do_start(16'h0010, 16'h0010);
      wait_done(40, cyc, ovl);
      checks++;
      if (product !== 32'h00000100 || done !== 1'b1) begin
         errors++; $display("FAIL b2b_first: got %h done=%b want 00000100/1", product, done);
      end
      // Start in the done cycle.
      start = 1'b1;
      a     = 16'h0100;
      b     = 16'h0100;
      cyc   = 0;
      do begin
         @(posedge clk);
         #1;
         cyc++;
         if (cyc == 1) start = 1'b0;
         if (!done && product !== 32'h00000100) hold_bad = 1'b1;
      end while (!done && cyc < 40);
      checks++;
      if (cyc !== 17 || done !== 1'b1) begin
         errors++; $display("FAIL b2b_spacing: got %0d cycles done=%b want 17/1", cyc, done);
      end
      checks++;
      if (product !== 32'h00010000) begin errors++; $display("FAIL b2b_product: got %h want 00010000", product); end
      checks++;
      if (hold_bad) begin errors++; $display("FAIL b2b_hold: got product change between dones want held 00000100"); end
      $display("op 0100*0100 back-to-back -> %h, spacing %0d cycles", product, cyc);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid();
      int  cyc;
      bit  ovl;
      bit  spurious = 1'b0;
      do_start(16'h00FF, 16'h00FF);
      repeat (7) @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== 32'h0) begin
         errors++; $display("FAIL reset_mid_clear: busy=%b done=%b product=%h want 0/0/00000000", busy, done, product);
      end
      @(posedge clk);
      #3 rst_n = 1'b1;
      for (int k = 0; k < 24; k++) begin
         @(posedge clk);
         #1;
         if (done || busy) spurious = 1'b1;
      end
      checks++;
      if (spurious) begin errors++; $display("FAIL reset_mid_no_resume: got busy/done after abort want none"); end
      do_start(16'h00FF, 16'h00FF);
      wait_done(40, cyc, ovl);
      checks++;
      if (cyc !== 16 || product !== 32'h0000FE01) begin
         errors++; $display("FAIL reset_mid_restart: got %h in %0d cycles want 0000fe01 in 16", product, cyc);
      end
      $display("op 00FF*00FF after abort -> %h in %0d cycles", product, cyc);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      a     = 16'h0;
      b     = 16'h0;
      test_reset();
      test_basic();
      test_products();
      test_busy_protect();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_shift_add_mult
